// File: rtl/universal_register_pkg.sv
// Shared mode encoding for the universal register and its next-state logic.
package universal_register_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROTL = 3'b100;
  localparam mode_t MODE_ROTR = 3'b101;
  localparam mode_t MODE_INC  = 3'b110;
  localparam mode_t MODE_DEC  = 3'b111;

endpackage

// File: rtl/universal_register_next.sv
// Combinational next-state logic: new contents, new serial-out bit and count-limit flag
// for the selected mode, assuming the operation is enabled.
module universal_register_next
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic [WIDTH-1:0] present_i,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             serial_in_i,
  input  logic             serial_q_i,
  output logic [WIDTH-1:0] next_o,
  output logic             serial_next_o,
  output logic             limit_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_o        = present_i;
    serial_next_o = serial_q_i;
    limit_o       = 1'b0;
    case (mode_i)
      MODE_HOLD: next_o = present_i;
      MODE_LOAD: next_o = d_i;
      MODE_SHL: begin
        next_o        = {present_i[WIDTH-2:0], serial_in_i};
        serial_next_o = present_i[WIDTH-1];
      end
      MODE_SHR: begin
        next_o        = {serial_in_i, present_i[WIDTH-1:1]};
        serial_next_o = present_i[0];
      end
      MODE_ROTL: begin
        next_o        = {present_i[WIDTH-2:0], present_i[WIDTH-1]};
        serial_next_o = present_i[WIDTH-1];
      end
      MODE_ROTR: begin
        next_o        = {present_i[0], present_i[WIDTH-1:1]};
        serial_next_o = present_i[0];
      end
      // At a limit the flag fires in both policies; only the stored value differs.
      MODE_INC: begin
        if (present_i == {WIDTH{1'b1}}) begin
          limit_o = 1'b1;
          next_o  = WRAP ? {WIDTH{1'b0}} : present_i;
        end else begin
          next_o = present_i + ONE;
        end
      end
      MODE_DEC: begin
        if (present_i == {WIDTH{1'b0}}) begin
          limit_o = 1'b1;
          next_o  = WRAP ? {WIDTH{1'b1}} : present_i;
        end else begin
          next_o = present_i - ONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// Parametrised state register with load, shift, rotate and up/down count modes.
// Holds only the flip-flops and the reset > clear > enable priority.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               WRAP        = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] D,
  input  logic             serial_in,
  output logic [WIDTH-1:0] present,
  output logic             serial_out,
  output logic             terminal
);

  logic [WIDTH-1:0] present_q, present_d;
  logic             serial_q, serial_d;
  logic             terminal_q, limit_d;

  universal_register_next #(
    .WIDTH(WIDTH),
    .WRAP (WRAP)
  ) u_next (
    .present_i    (present_q),
    .mode_i       (mode),
    .d_i          (D),
    .serial_in_i  (serial_in),
    .serial_q_i   (serial_q),
    .next_o       (present_d),
    .serial_next_o(serial_d),
    .limit_o      (limit_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      present_q  <= RESET_VALUE;
      serial_q   <= 1'b0;
      terminal_q <= 1'b0;
    end else if (clear) begin
      present_q  <= '0;
      serial_q   <= 1'b0;
      terminal_q <= 1'b0;
    end else if (enable) begin
      present_q  <= present_d;
      serial_q   <= serial_d;
      terminal_q <= limit_d;
    end else begin
      terminal_q <= 1'b0;
    end
  end

  assign present    = present_q;
  assign serial_out = serial_q;
  assign terminal   = terminal_q;

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: a wrapping and a saturating instance share stimulus
// and are compared against an arithmetic reference model plus a directed vector table.
module tb_universal_register;
  import universal_register_pkg::*;

  localparam int W = 4;
  localparam logic [W-1:0] RV = 4'hA;

  logic         clock = 1'b0;
  logic         reset, clear, enable, serial_in;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] present_w, present_s;
  logic         sout_w, sout_s, term_w, term_s;

  int checks = 0;
  int errors = 0;
  int mp[2], ms[2], mt[2];

  always #5 clock = ~clock;

  universal_register #(.WIDTH(W), .RESET_VALUE(RV), .WRAP(1'b1)) dut_wrap (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .D(d), .serial_in(serial_in), .present(present_w), .serial_out(sout_w), .terminal(term_w));

  universal_register #(.WIDTH(W), .RESET_VALUE(RV), .WRAP(1'b0)) dut_sat (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .D(d), .serial_in(serial_in), .present(present_s), .serial_out(sout_s), .terminal(term_s));

  typedef struct {
    logic       clr;
    logic       en;
    logic [2:0] md;
    logic [3:0] dd;
    logic       sin;
    logic [3:0] ep;
    logic       es;
    logic       et;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic clr, logic en, logic [2:0] md, logic [3:0] dd, logic sin,
                              logic [3:0] ep, logic es, logic et);
    vec_t v;
    v.clr = clr; v.en = en; v.md = md; v.dd = dd; v.sin = sin;
    v.ep = ep; v.es = es; v.et = et;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model in plain arithmetic; k=0 wraps, k=1 saturates.
  task automatic model_step(input int k);
    int top, half, wrap;
    top  = (1 << W) - 1;
    half = 1 << (W - 1);
    wrap = (k == 0) ? 1 : 0;
    mt[k] = 0;
    if (clear) begin
      mp[k] = 0;
      ms[k] = 0;
    end else if (enable) begin
      case (mode)
        MODE_LOAD: mp[k] = int'(d);
        MODE_SHL: begin
          ms[k] = (mp[k] >= half) ? 1 : 0;
          mp[k] = (mp[k] * 2 + int'(serial_in)) % (top + 1);
        end
        MODE_SHR: begin
          ms[k] = mp[k] % 2;
          mp[k] = mp[k] / 2 + int'(serial_in) * half;
        end
        MODE_ROTL: begin
          ms[k] = (mp[k] >= half) ? 1 : 0;
          mp[k] = (mp[k] * 2) % (top + 1) + ms[k];
        end
        MODE_ROTR: begin
          ms[k] = mp[k] % 2;
          mp[k] = mp[k] / 2 + ms[k] * half;
        end
        MODE_INC: begin
          if (mp[k] == top) begin
            mt[k] = 1;
            mp[k] = wrap ? 0 : top;
          end else mp[k] = mp[k] + 1;
        end
        MODE_DEC: begin
          if (mp[k] == 0) begin
            mt[k] = 1;
            mp[k] = wrap ? top : 0;
          end else mp[k] = mp[k] - 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mp[k] = int'(RV); ms[k] = 0; mt[k] = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_present_wrap"}, int'(present_w), mp[0]);
    check({tag, "_sout_wrap"},    int'(sout_w),    ms[0]);
    check({tag, "_term_wrap"},    int'(term_w),    mt[0]);
    check({tag, "_present_sat"},  int'(present_s), mp[1]);
    check({tag, "_sout_sat"},     int'(sout_s),    ms[1]);
    check({tag, "_term_sat"},     int'(term_s),    mt[1]);
  endtask

  task automatic step(input logic clr, input logic en, input logic [2:0] md,
                      input logic [3:0] dd, input logic sin, input string tag);
    clear = clr; enable = en; mode = md; d = dd; serial_in = sin;
    model_step(0);
    model_step(1);
    @(posedge clock);
    #1;
    $display("%s clr=%0b en=%0b mode=%0d D=%h sin=%0b -> wrap:%h/%0b/%0b sat:%h/%0b/%0b",
             tag, clr, en, md, dd, sin, present_w, sout_w, term_w, present_s, sout_s, term_s);
    compare_model(tag);
  endtask

  task automatic reset_between_edges(input string tag);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    $display("%s async reset -> wrap:%h/%0b/%0b sat:%h/%0b/%0b",
             tag, present_w, sout_w, term_w, present_s, sout_s, term_s);
    check({tag, "_rst_present"}, int'(present_w), int'(RV));
    compare_model({tag, "_rst"});
    @(posedge clock);
    #1;
    compare_model({tag, "_rst_hold"});
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, MODE_HOLD, 4'h0, 0, 4'hA, 0, 0);
    vecs[1]  = mk(0, 0, MODE_LOAD, 4'h3, 1, 4'hA, 0, 0);
    vecs[2]  = mk(0, 0, MODE_INC,  4'h0, 0, 4'hA, 0, 0);
    vecs[3]  = mk(0, 1, MODE_LOAD, 4'h9, 0, 4'h9, 0, 0);
    vecs[4]  = mk(0, 1, MODE_SHL,  4'h0, 1, 4'h3, 1, 0);
    vecs[5]  = mk(0, 1, MODE_SHR,  4'h0, 0, 4'h1, 1, 0);
    vecs[6]  = mk(0, 1, MODE_LOAD, 4'h8, 0, 4'h8, 1, 0);
    vecs[7]  = mk(0, 1, MODE_ROTL, 4'h0, 0, 4'h1, 1, 0);
    vecs[8]  = mk(0, 1, MODE_ROTL, 4'h0, 0, 4'h2, 0, 0);
    vecs[9]  = mk(0, 1, MODE_ROTL, 4'h0, 0, 4'h4, 0, 0);
    vecs[10] = mk(0, 1, MODE_ROTL, 4'h0, 0, 4'h8, 0, 0);
    vecs[11] = mk(0, 1, MODE_LOAD, 4'hE, 0, 4'hE, 0, 0);
    vecs[12] = mk(0, 1, MODE_INC,  4'h0, 0, 4'hF, 0, 0);
    vecs[13] = mk(0, 1, MODE_INC,  4'h0, 0, 4'h0, 0, 1);
    vecs[14] = mk(0, 1, MODE_INC,  4'h0, 0, 4'h1, 0, 0);
    vecs[15] = mk(0, 1, MODE_LOAD, 4'h0, 0, 4'h0, 0, 0);
    vecs[16] = mk(0, 1, MODE_DEC,  4'h0, 0, 4'hF, 0, 1);
    vecs[17] = mk(0, 1, MODE_DEC,  4'h0, 0, 4'hE, 0, 0);
    vecs[18] = mk(1, 1, MODE_LOAD, 4'h7, 0, 4'h0, 0, 0);
    vecs[19] = mk(0, 1, MODE_HOLD, 4'h5, 1, 4'h0, 0, 0);
    vecs[20] = mk(0, 1, MODE_LOAD, 4'h1, 0, 4'h1, 0, 0);
    vecs[21] = mk(0, 1, MODE_ROTR, 4'h0, 0, 4'h8, 1, 0);
    vecs[22] = mk(0, 1, MODE_SHR,  4'h0, 1, 4'hC, 0, 0);
    vecs[23] = mk(0, 0, MODE_INC,  4'h0, 0, 4'hC, 0, 0);
    vecs[24] = mk(1, 0, MODE_HOLD, 4'h0, 0, 4'h0, 0, 0);
    vecs[25] = mk(0, 1, MODE_DEC,  4'h0, 0, 4'hF, 0, 1);

    reset = 1'b1; clear = 1'b0; enable = 1'b0; mode = MODE_HOLD; d = '0; serial_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    $display("reset state -> wrap:%h/%0b/%0b sat:%h/%0b/%0b",
             present_w, sout_w, term_w, present_s, sout_s, term_s);
    check("reset_present", int'(present_w), int'(RV));
    compare_model("reset");

    for (int i = 0; i < 26; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].clr, vecs[i].en, vecs[i].md, vecs[i].dd, vecs[i].sin, tag);
      check({tag, "_tbl_present"}, int'(present_w), int'(vecs[i].ep));
      check({tag, "_tbl_sout"},    int'(sout_w),    int'(vecs[i].es));
      check({tag, "_tbl_term"},    int'(term_w),    int'(vecs[i].et));
    end

    // Reset mid-count, with clear and enable also active.
    step(0, 1, MODE_INC, 4'h0, 0, "midcount");
    step(0, 1, MODE_INC, 4'h0, 0, "midcount");
    clear = 1'b1; enable = 1'b1; mode = MODE_LOAD; d = 4'h7;
    reset_between_edges("midcount");
    for (int i = 0; i < 3; i++) step(0, 0, MODE_INC, 4'h0, 0, "idle");
    check("idle_present", int'(present_w), int'(RV));

    // Saturating boundaries.
    step(0, 1, MODE_LOAD, 4'hF, 0, "sat_load");
    step(0, 1, MODE_INC,  4'h0, 0, "sat_inc1");
    check("sat_inc1_present", int'(present_s), 15);
    check("sat_inc1_term",    int'(term_s),    1);
    step(0, 1, MODE_INC,  4'h0, 0, "sat_inc2");
    check("sat_inc2_present", int'(present_s), 15);
    check("sat_inc2_term",    int'(term_s),    1);
    step(0, 1, MODE_LOAD, 4'h0, 0, "sat_load0");
    step(0, 1, MODE_DEC,  4'h0, 0, "sat_dec");
    check("sat_dec_present", int'(present_s), 0);
    check("sat_dec_term",    int'(term_s),    1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        clear = 1'($urandom_range(0, 1)); enable = 1'($urandom_range(0, 1));
        reset_between_edges($sformatf("rnd%0d", i));
      end else begin
        step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
             3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
